rx_sample_packer: RTL and testbench



---
 rtl/rx_sample_packer.sv | 135 +++++++++++++
 tb/tb_rx_sample_packer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_sample_packer.sv
// rx_sample_packer: decimates the radio I/Q strobe, packs each kept sample as {Q,I}, and buffers
// the words in a 2-entry skid FIFO in front of an AXI-Stream master. Kept samples that arrive
// while the buffer is full and not draining are dropped and counted.
module rx_sample_packer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DECIM_W = 8,
  parameter int unsigned OVF_W   = 16
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                enable,
  input  logic [DECIM_W-1:0]  decim,
  input  logic                clear_ovf,
  input  logic [DATA_W-1:0]   in_i,
  input  logic [DATA_W-1:0]   in_q,
  input  logic                in_valid,
  output logic [2*DATA_W-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [OVF_W-1:0]    ovf_count,
  output logic                ovf_sticky,
  output logic                busy
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q, state_d;
  logic [DECIM_W-1:0]    dcnt_q, dcnt_d;
  logic [2*DATA_W-1:0]   mem_q [2];
  logic [2*DATA_W-1:0]   mem_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [OVF_W-1:0]      ovf_q, ovf_d;
  logic                  sticky_q, sticky_d;

  logic strobe, keep, full, pop, push, drop, wr_idx;

  // Control decode: which strobes count, and what the buffer does this cycle
  always_comb begin
    strobe = (state_q == StRun) && enable && in_valid;
    keep   = strobe && (dcnt_q == '0);
    full   = (cnt_q == 2'd2);
    pop    = (cnt_q != 2'd0) && m_axis_tready;
    // A full buffer still accepts a word when its head leaves in the same cycle
    push   = keep && (!full || pop);
    drop   = keep && full && !pop;
    // Free slot sits one past the head when holding one word, else at the head itself
    wr_idx = rd_ptr_q ^ cnt_q[0];
  end

  // FSM next state and decimation counter
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      StIdle: if (enable) state_d = StRun;
      StRun:  if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (state_q == StIdle) begin
      // Holding zero while idle guarantees the first strobe after entry is kept
      dcnt_d = '0;
    end else if (strobe) begin
      if (decim <= DECIM_W'(1)) begin
        dcnt_d = '0;
      end else if (dcnt_q >= decim - DECIM_W'(1)) begin
        // >= rather than == so a shrinking ratio cannot strand the counter
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + DECIM_W'(1);
      end
    end
  end

  // Buffer next state: storage, head pointer and occupancy
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) mem_d[wr_idx] = {in_q, in_i};
    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Overflow counter: clear is applied first so a coincident drop still registers as one
  always_comb begin
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    if (clear_ovf) begin
      ovf_d    = '0;
      sticky_d = 1'b0;
    end
    if (drop) begin
      if (ovf_d != '1) ovf_d = ovf_d + OVF_W'(1);
      sticky_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= StIdle;
      dcnt_q   <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ovf_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  // Outputs come straight from registers; no path from in_valid to tvalid
  always_comb begin
    m_axis_tvalid = (cnt_q != 2'd0);
    m_axis_tdata  = mem_q[rd_ptr_q];
    ovf_count     = ovf_q;
    ovf_sticky    = sticky_q;
    busy          = enable | m_axis_tvalid;
  end

endmodule

// File: tb/tb_rx_sample_packer.sv
// Directed bench for rx_sample_packer. A second instance with a 2-bit overflow counter shares
// the stimulus to exercise saturation.
module tb_rx_sample_packer;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        enable;
  logic [7:0]  decim;
  logic        clear_ovf;
  logic [15:0] in_i, in_q;
  logic        in_valid;
  logic        tready;

  logic [31:0] tdata, s_tdata;
  logic        tvalid, s_tvalid;
  logic [15:0] ovf;
  logic [1:0]  s_ovf;
  logic        sticky, s_sticky, busy, s_busy;

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  rx_sample_packer dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .decim(decim), .clear_ovf(clear_ovf),
    .in_i(in_i), .in_q(in_q), .in_valid(in_valid), .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .ovf_count(ovf), .ovf_sticky(sticky),
    .busy(busy)
  );

  rx_sample_packer #(.OVF_W(2)) dut_s (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .decim(decim), .clear_ovf(clear_ovf),
    .in_i(in_i), .in_q(in_q), .in_valid(in_valid), .m_axis_tdata(s_tdata),
    .m_axis_tvalid(s_tvalid), .m_axis_tready(tready), .ovf_count(s_ovf),
    .ovf_sticky(s_sticky), .busy(s_busy)
  );

  // Advance one edge; outputs are then sampled and inputs changed 1 time unit later
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] i, input logic [15:0] q);
    in_i     = i;
    in_q     = q;
    in_valid = 1'b1;
    tick();
  endtask

  initial begin
    ARESETN   = 1'b0;
    enable    = 1'b0;
    decim     = 8'd0;
    clear_ovf = 1'b0;
    in_i      = '0;
    in_q      = '0;
    in_valid  = 1'b0;
    tready    = 1'b1;
    tick();
    tick();
    ARESETN = 1'b1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_sticky", 32'(sticky), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Full rate, 1-cycle latency, sustained throughput
    enable = 1'b1;
    tick();
    check("en_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      strobe(16'(k + 1), 16'(16'h1000 + k));
      check("fr_tvalid", 32'(tvalid), 32'd1);
      check("fr_tdata", tdata, {16'(16'h1000 + k), 16'(k + 1)});
    end
    in_valid = 1'b0;
    tick();
    check("fr_empty", 32'(tvalid), 32'd0);
    check("fr_ovf", 32'(ovf), 32'd0);

    // Decimate by 3: keep i = 1, 4, 7
    decim = 8'd3;
    for (int k = 1; k <= 9; k++) begin
      strobe(16'(k), 16'h0000);
      check("dec_tvalid", 32'(tvalid), 32'((k == 1) || (k == 4) || (k == 7)));
      if ((k == 1) || (k == 4) || (k == 7)) check("dec_tdata", tdata, 32'(k));
    end
    in_valid = 1'b0;
    decim    = 8'd0;
    tick();
    check("dec_empty", 32'(tvalid), 32'd0);

    // Backpressure: 5 kept strobes, 2 buffered, 3 dropped
    tready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      strobe(16'(k), 16'h0000);
      check("bp_hold", tdata, 32'd1);
    end
    in_valid = 1'b0;
    check("bp_ovf", 32'(ovf), 32'd3);
    check("bp_ovf_s", 32'(s_ovf), 32'd3);
    check("bp_sticky", 32'(sticky), 32'd1);
    tready = 1'b1;
    tick();
    check("bp_w2_valid", 32'(tvalid), 32'd1);
    check("bp_w2_data", tdata, 32'd2);
    tick();
    check("bp_drained", 32'(tvalid), 32'd0);

    // Full buffer with push and pop together: no drop, stays at 2
    tready = 1'b0;
    strobe(16'h0011, 16'h0000);
    strobe(16'h0012, 16'h0000);
    tready = 1'b1;
    strobe(16'h0013, 16'h0000);
    check("pp_head", tdata, 32'h12);
    check("pp_ovf", 32'(ovf), 32'd3);
    in_valid = 1'b0;
    tready   = 1'b0;
    tick();
    check("pp_hold", tdata, 32'h12);
    tready = 1'b1;
    tick();
    check("pp_second_valid", 32'(tvalid), 32'd1);
    check("pp_second_data", tdata, 32'h13);
    tick();
    check("pp_empty", 32'(tvalid), 32'd0);

    // Clear, then 6 drops: wide counter reads 6, 2-bit counter saturates at 3
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_sticky", 32'(sticky), 32'd0);
    tready = 1'b0;
    strobe(16'h0021, 16'h0000);
    strobe(16'h0022, 16'h0000);
    for (int k = 0; k < 6; k++) strobe(16'(16'h0030 + k), 16'h0000);
    check("sat_ovf", 32'(ovf), 32'd6);
    check("sat_ovf_s", 32'(s_ovf), 32'd3);
    check("sat_sticky_s", 32'(s_sticky), 32'd1);
    clear_ovf = 1'b1;
    strobe(16'h003f, 16'h0000);
    clear_ovf = 1'b0;
    in_valid  = 1'b0;
    check("clrdrop_ovf", 32'(ovf), 32'd1);
    check("clrdrop_ovf_s", 32'(s_ovf), 32'd1);
    check("clrdrop_sticky", 32'(sticky), 32'd1);
    check("full_head", tdata, 32'h21);

    // Disable with 2 words buffered; strobes ignored while the buffer drains
    enable = 1'b0;
    tready = 1'b1;
    strobe(16'h0077, 16'h0000);
    check("dis_w2", tdata, 32'h22);
    check("dis_busy1", 32'(busy), 32'd1);
    strobe(16'h0077, 16'h0000);
    check("dis_empty", 32'(tvalid), 32'd0);
    check("dis_busy0", 32'(busy), 32'd0);
    strobe(16'h0077, 16'h0000);
    check("dis_no_new", 32'(tvalid), 32'd0);
    check("dis_ovf", 32'(ovf), 32'd1);
    in_valid = 1'b0;

    // Reset while words are buffered
    enable = 1'b1;
    tick();
    tready = 1'b0;
    strobe(16'h0041, 16'h0000);
    strobe(16'h0042, 16'h0000);
    in_valid = 1'b0;
    enable   = 1'b0;
    check("mid_valid", 32'(tvalid), 32'd1);
    ARESETN = 1'b0;
    tick();
    check("mid_rst_valid", 32'(tvalid), 32'd0);
    check("mid_rst_data", tdata, 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_sticky", 32'(sticky), 32'd0);
    ARESETN = 1'b1;
    tready  = 1'b1;
    tick();
    check("post_rst_valid", 32'(tvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
